// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: owns HI/LO, computes the result at the
// start edge and commits it after a fixed MULT_CYCLES or DIV_CYCLES busy window.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDUEN,
  input  logic [2:0]  MDUCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        MDUBusy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] phi_q, plo_q;
  logic        pwr_q;

  logic        is_div, is_signed, b_zero;
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;
  logic [31:0] res_hi_d, res_lo_d;

  // ctrl[1] selects divide, ctrl[0] selects unsigned for the four long ops
  always_comb begin
    is_div    = MDUCtrl[1];
    is_signed = ~MDUCtrl[0];
    b_zero    = (B == 32'd0);
    a_ext     = is_signed ? {{32{A[31]}}, A} : {32'd0, A};
    b_ext     = is_signed ? {{32{B[31]}}, B} : {32'd0, B};
    prod      = a_ext * b_ext;
    a_neg     = is_signed & A[31];
    b_neg     = is_signed & B[31];
    a_mag     = a_neg ? (32'd0 - A) : A;
    b_mag     = b_zero ? 32'd1 : (b_neg ? (32'd0 - B) : B);
    q_mag     = a_mag / b_mag;
    r_mag     = a_mag % b_mag;
    res_hi_d  = prod[63:32];
    res_lo_d  = prod[31:0];
    // Magnitude divide makes 0x80000000 / -1 fall out as 0x80000000 rem 0.
    if (is_div) begin
      res_lo_d = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      res_hi_d = a_neg ? (32'd0 - r_mag) : r_mag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      pwr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MDUEN) begin
            if (!MDUCtrl[2]) begin
              phi_q   <= res_hi_d;
              plo_q   <= res_lo_d;
              pwr_q   <= ~(is_div & b_zero);
              cnt_q   <= is_div ? DIV_LAT : MULT_LAT;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end else if (MDUCtrl == OP_MTHI) begin
              hi_q <= A;
            end else if (MDUCtrl == OP_MTLO) begin
              lo_q <= A;
            end
          end
        end
        RUN: begin
          if (cnt_q == 4'd0) begin
            if (pwr_q) begin
              hi_q <= phi_q;
              lo_q <= plo_q;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MDUBusy = busy_q;
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed scenarios plus a random sweep, expected HI/LO pairs
// queued at operation start and compared when the busy window closes.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        MDUEN;
  logic [2:0]  MDUCtrl;
  logic [31:0] A, B;
  logic        MDUBusy;
  logic [31:0] HI, LO;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDUEN(MDUEN), .MDUCtrl(MDUCtrl),
    .A(A), .B(B), .MDUBusy(MDUBusy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Reference model; divide by zero leaves the tracked HI/LO untouched.
  function automatic logic [63:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = {m_hi, m_lo};
    case (c)
      3'd0: p = 64'(sa * sb);
      3'd1: p = ua * ub;
      3'd2: if (b != 32'd0) begin
        sq = sa / sb;
        sr = sa % sb;
        p  = {sr[31:0], sq[31:0]};
      end
      3'd3: if (b != 32'd0) begin
        uq = ua / ub;
        ur = ua % ub;
        p  = {ur[31:0], uq[31:0]};
      end
      default: ;
    endcase
    return p;
  endfunction

  // Called at a negedge; the following posedge samples the op.
  task automatic start_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    MDUEN = 1'b1; MDUCtrl = c; A = a; B = b;
    @(negedge clk);
    MDUEN = 1'b0; MDUCtrl = 3'($urandom_range(0, 7)); A = $urandom; B = $urandom;
  endtask

  task automatic wait_done(output int cyc, output logic held);
    logic [31:0] h0, l0;
    h0 = HI; l0 = LO; cyc = 0; held = 1'b1;
    while (MDUBusy === 1'b1 && cyc < 40) begin
      if (HI !== h0 || LO !== l0) held = 1'b0;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; MDUEN = 1'b0; MDUCtrl = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clk);
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", LO); end
    checks++; if (MDUBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", MDUBusy); end
    reset = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int cyc; logic held; logic [63:0] e;
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFA);
    start_op(3'd0, 32'hFFFFFFFE, 32'd3);
    wait_done(cyc, held);
    checks++; if (cyc != 5) begin errors++; $display("FAIL mult_busy: got %0d cycles expected 5", cyc); end
    checks++; if (!held) begin errors++; $display("FAIL mult_hold: HI/LO changed while busy, expected 0"); end
    e = exp_q.pop_front();
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL mult_result: got %h expected %h", {HI, LO}, e); end
    {m_hi, m_lo} = e;
    exp_q.push_back(64'h00000001_FFFFFFFE);
    start_op(3'd1, 32'hFFFFFFFF, 32'd2);
    wait_done(cyc, held);
    checks++; if (cyc != 5) begin errors++; $display("FAIL multu_busy: got %0d cycles expected 5", cyc); end
    e = exp_q.pop_front();
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL multu_result: got %h expected %h", {HI, LO}, e); end
    {m_hi, m_lo} = e;
  endtask

  task automatic test_div();
    int cyc; logic held; logic [63:0] e;
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    start_op(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_done(cyc, held);
    checks++; if (cyc != 10) begin errors++; $display("FAIL div_busy: got %0d cycles expected 10", cyc); end
    checks++; if (!held) begin errors++; $display("FAIL div_hold: HI/LO changed while busy"); end
    e = exp_q.pop_front();
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL div_result: got %h expected %h", {HI, LO}, e); end
    {m_hi, m_lo} = e;
    exp_q.push_back({32'd2, 32'd14});
    start_op(3'd3, 32'd100, 32'd7);
    wait_done(cyc, held);
    e = exp_q.pop_front();
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL divu_result: got %h expected %h", {HI, LO}, e); end
    {m_hi, m_lo} = e;
    exp_q.push_back(64'h80000000_00000000 >> 32 | 64'h0);
    exp_q.pop_back();
    exp_q.push_back({32'd0, 32'h80000000});
    start_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(cyc, held);
    e = exp_q.pop_front();
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL div_overflow: got %h expected %h", {HI, LO}, e); end
    {m_hi, m_lo} = e;
  endtask

  task automatic test_div_zero();
    int cyc; logic held; logic [63:0] e;
    start_op(3'd4, 32'h00001234, 32'd0);
    m_hi = 32'h00001234;
    checks++; if (HI !== 32'h00001234) begin errors++; $display("FAIL mthi_value: got %h expected 00001234", HI); end
    exp_q.push_back({m_hi, m_lo});
    start_op(3'd3, 32'd55, 32'd0);
    wait_done(cyc, held);
    checks++; if (cyc != 10) begin errors++; $display("FAIL divzero_busy: got %0d cycles expected 10", cyc); end
    e = exp_q.pop_front();
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL divzero_result: got %h expected %h", {HI, LO}, e); end
  endtask

  task automatic test_mtlo_ignore();
    int cyc; logic held; logic [63:0] e;
    start_op(3'd5, 32'hDEADBEEF, 32'd0);
    m_lo = 32'hDEADBEEF;
    checks++; if (LO !== 32'hDEADBEEF) begin errors++; $display("FAIL mtlo_value: got %h expected deadbeef", LO); end
    checks++; if (MDUBusy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b expected 0", MDUBusy); end
    MDUEN = 1'b1; MDUCtrl = 3'd6; A = 32'h77777777;
    @(negedge clk);
    MDUEN = 1'b0;
    checks++; if ({MDUBusy, HI, LO} !== {1'b0, m_hi, m_lo}) begin
      errors++; $display("FAIL reserved_op: got %h expected %h", {MDUBusy, HI, LO}, {1'b0, m_hi, m_lo});
    end
    exp_q.push_back(model(3'd0, 32'd7, 32'd6));
    start_op(3'd0, 32'd7, 32'd6);
    MDUEN = 1'b1; MDUCtrl = 3'd4; A = 32'h55555555;
    repeat (2) @(negedge clk);
    MDUEN = 1'b0;
    wait_done(cyc, held);
    checks++; if (cyc != 3) begin errors++; $display("FAIL ignore_busy: got %0d remaining cycles expected 3", cyc); end
    e = exp_q.pop_front();
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL ignore_result: got %h expected %h", {HI, LO}, e); end
    {m_hi, m_lo} = e;
  endtask

  task automatic test_back_to_back();
    int cyc; logic held; logic [63:0] e;
    exp_q.push_back(model(3'd1, 32'h12345678, 32'h9ABCDEF0));
    start_op(3'd1, 32'h12345678, 32'h9ABCDEF0);
    wait_done(cyc, held);
    {m_hi, m_lo} = exp_q[0];
    exp_q.push_back(model(3'd2, 32'hFFFF0000, 32'd9));
    e = exp_q.pop_front();
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL b2b_first: got %h expected %h", {HI, LO}, e); end
    start_op(3'd2, 32'hFFFF0000, 32'd9);
    checks++; if (MDUBusy !== 1'b1) begin errors++; $display("FAIL b2b_start: got busy %b expected 1", MDUBusy); end
    wait_done(cyc, held);
    checks++; if (cyc != 10) begin errors++; $display("FAIL b2b_busy: got %0d cycles expected 10", cyc); end
    e = exp_q.pop_front();
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL b2b_second: got %h expected %h", {HI, LO}, e); end
    {m_hi, m_lo} = e;
  endtask

  task automatic test_random();
    int cyc; logic held; logic [63:0] e; logic [2:0] c; logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      c = 3'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      exp_q.push_back(model(c, a, b));
      start_op(c, a, b);
      wait_done(cyc, held);
      checks++; if (cyc != (c[1] ? 10 : 5)) begin errors++; $display("FAIL rand_busy[%0d]: got %0d cycles op %0d", i, cyc, c); end
      e = exp_q.pop_front();
      checks++; if ({HI, LO} !== e) begin
        errors++; $display("FAIL rand_result[%0d]: op %0d a %h b %h got %h expected %h", i, c, a, b, {HI, LO}, e);
      end
      {m_hi, m_lo} = e;
    end
  endtask

  task automatic test_reset_mid();
    start_op(3'd2, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if ({MDUBusy, HI, LO} !== 65'd0) begin errors++; $display("FAIL async_reset: got %h expected 0", {MDUBusy, HI, LO}); end
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if ({MDUBusy, HI, LO} !== 65'd0) begin errors++; $display("FAIL reset_discard: got %h expected 0", {MDUBusy, HI, LO}); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_mtlo_ignore();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
